saucer_scheduler: RTL
=====================

Name: saucer_scheduler

Overview:
- Controls the two rescue saucers (left slot 0, right slot 1) of a level.
- Each saucer is drawn and moved by its own soucoupe layer; this block drives each layer's enable and mode_saucer inputs and reads back its qb_on_sc and done_move_sc outputs.
- Decides which saucer Qbert boards and freezes Qbert's own motion during the ride.
- After the ride and a settle delay, marks that saucer as consumed and hands control back to Qbert.

Parameters:
- LAND_CYCLES, 32'd2_000_000: settle delay after saucer arrival, before Qbert is released.
- RIDE_TIMEOUT, 32'd50_000_000: RIDE watchdog; when it expires the ride is aborted and the saucer consumed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- level_start  in  1  1-cycle pulse at start of a level
- e_pause  in  1  pause pulse
- e_resume  in  1  resume pulse
- e_start  in  1  restart pulse; honoured only while paused
- qbert_landed  in  1  1-cycle pulse when a Qbert jump ends
- qb_on_sc  in  2  per-slot "Qbert on saucer" flags from the layers
- done_move_sc  in  2  per-slot "move done" flags from the layers
- enable_sc  out  2  per-slot enable to the layers
- mode_saucer  out  2  per-slot "start moving" to the layers
- ride_active  out  1  high from boarding until release
- ride_sel  out  1  slot currently riding
- qbert_freeze  out  1  holds Qbert's own motion
- ride_done  out  1  1-cycle pulse on release
- ride_abort  out  1  1-cycle pulse on watchdog expiry
- sc_used  out  2  consumed-saucer mask
- all_used  out  1  high when sc_used == 2'b11

Behaviour:
- Clock, reset and registers
  - All state changes on posedge clk.
  - reset=0 forces: state IDLE, paused=0, cnt=0, and every output 0 (enable_sc, mode_saucer, sc_used, ride_sel, all pulses).
  - All outputs are registered.
- States: IDLE, ARMED, RIDE, LAND.
- IDLE
  - Outputs quiet.
  - level_start: sc_used<=0, enable_sc<=2'b11, state ARMED.
- ARMED
  - enable_sc = ~sc_used; mode_saucer=0.
  - Boarding: on qbert_landed with c = qb_on_sc & ~sc_used nonzero:
    - i = lowest set bit of c (slot 0 wins a tie);
    - ride_sel<=i, mode_saucer[i]<=1, qbert_freeze<=1, ride_active<=1;
    - cnt<=0, state RIDE.
  - qbert_landed with c==0 is ignored.
  - qb_on_sc without qbert_landed is ignored (a pass-through does not board).
- RIDE
  - mode_saucer[ride_sel] held at 1; cnt increments every cycle.
  - done_move_sc[ride_sel]=1: cnt<=0, state LAND.
  - Else cnt==RIDE_TIMEOUT-1: ride_abort pulse, then the release actions below, state ARMED.
  - done_move_sc on the non-selected slot is ignored.
- LAND
  - cnt increments each cycle.
  - Release at cnt==LAND_CYCLES-1:
    - sc_used[ride_sel]<=1, enable_sc[ride_sel]<=0, mode_saucer<=0;
    - qbert_freeze<=0, ride_active<=0;
    - ride_done pulse; state ARMED.
  - Release latency from done_move_sc rise: exactly LAND_CYCLES+1 cycles to ride_done.
- all_used = (sc_used == 2'b11), registered alongside sc_used.
- level_start in any non-IDLE state behaves as a level restart:
  - mode_saucer<=0, qbert_freeze<=0, ride_active<=0;
  - sc_used<=0, enable_sc<=2'b11, state ARMED.
  - No ride_done pulse.
- Pause
  - e_pause sets paused (any state except IDLE).
  - While paused: cnt, state and all outputs frozen; qbert_landed and level_start ignored.
  - e_resume clears paused.
  - e_start while paused: full clear equivalent to reset, except reset stays high.
  - e_pause and e_resume in the same cycle: pause wins.
  - e_start while not paused: ignored.
- Width rules
  - cnt is 32-bit unsigned; compares use ==.
  - LAND_CYCLES >= 1 is required.

Decomposition:
- Shared package holds the state enum (IDLE, ARMED, RIDE, LAND as logic[1:0]) and the slot-index typedef.
- One natural sub-module, saucer_pick: combinational lowest-set-bit select of qb_on_sc & ~sc_used.
  - Outputs: valid and index.

Test Plan:
- reset=0 for 3 cycles, then 1; level_start -> enable_sc=2'b11, sc_used=0, state ARMED, all other outputs 0.
- Normal ride, LAND_CYCLES=4: qb_on_sc=2'b10 with qbert_landed; done_move_sc[1] rises 20 cycles later.
  - Next cycle: mode_saucer=2'b10, qbert_freeze=1.
  - ride_done 5 cycles after done_move_sc rise; then sc_used=2'b10, enable_sc=2'b01.
- Tie: qb_on_sc=2'b11 with qbert_landed -> ride_sel=0, mode_saucer=2'b01.
  - Repeat after release -> ride_sel=1; after that release all_used=1, enable_sc=0.
- Pause mid-LAND: e_pause at cnt=2, hold 100 cycles, e_resume -> ride_done delayed by exactly 100 cycles; outputs unchanged while paused.
- Watchdog, RIDE_TIMEOUT=50: board slot 0, never assert done_move_sc.
  - ride_abort pulse at RIDE cycle 50; sc_used=2'b01, qbert_freeze=0.
- Restart: e_pause then e_start during RIDE -> next cycle state IDLE, all outputs 0; qbert_landed ignored until level_start.

Source files
------------

// File: rtl/saucer_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : saucer_scheduler_pkg                                      |
// | Purpose: Shared types for the rescue-saucer scheduler: FSM state   |
// |          encoding, saucer slot index and a slot-to-mask helper.    |
// | Ports  : none (package)                                            |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package saucer_scheduler_pkg;

   localparam int unsigned NUM_SLOTS = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RIDE  = 2'd2,
      ST_LAND  = 2'd3
   } state_e;

   // Slot 0 is the left saucer, slot 1 the right one.
   typedef logic slot_t;

   // One-hot mask for a slot index.
   function automatic logic [NUM_SLOTS-1:0] slot_mask(input slot_t s);
      slot_mask = (s == 1'b1) ? 2'b10 : 2'b01;
   endfunction

endpackage : saucer_scheduler_pkg
`default_nettype wire

// File: rtl/saucer_scheduler_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : saucer_pick                                               |
// | Purpose: Chooses which saucer Qbert boards: lowest set bit of      |
// |          (qb_on_sc & ~sc_used); slot 0 wins a tie.                 |
// | Ports  : qb_on_sc_i [1:0] - per-slot "Qbert on saucer"             |
// |          sc_used_i  [1:0] - consumed-saucer mask                   |
// |          valid_o          - at least one boardable saucer          |
// |          idx_o            - chosen slot (meaningful when valid_o)  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module saucer_pick
   import saucer_scheduler_pkg::*;
(
   input  logic [1:0] qb_on_sc_i,
   input  logic [1:0] sc_used_i,
   output logic       valid_o,
   output slot_t      idx_o
);

   logic [1:0] w_cand;

   assign w_cand  = qb_on_sc_i & ~sc_used_i;
   assign valid_o = |w_cand;
   // With only two slots, slot 1 is chosen exactly when slot 0 is not a candidate.
   assign idx_o   = ~w_cand[0];

endmodule : saucer_pick
`default_nettype wire

// File: rtl/saucer_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : saucer_scheduler                                          |
// | Purpose: Runs the two rescue saucers of a level: arms the layers,  |
// |          boards Qbert, freezes his motion during the ride, waits   |
// |          a settle delay after arrival, then consumes the saucer.   |
// |          Includes a ride watchdog and pause/resume/restart.        |
// | Ports  : clk, reset (sync, active-low)                             |
// |          level_start, e_pause, e_resume, e_start, qbert_landed     |
// |          qb_on_sc[1:0], done_move_sc[1:0]  - from saucer layers    |
// |          enable_sc[1:0], mode_saucer[1:0]  - to saucer layers      |
// |          ride_active, ride_sel, qbert_freeze, ride_done,           |
// |          ride_abort, sc_used[1:0], all_used - all registered       |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module saucer_scheduler
   import saucer_scheduler_pkg::*;
#(
   parameter logic [31:0] LAND_CYCLES  = 32'd2_000_000,  // must be >= 1
   parameter logic [31:0] RIDE_TIMEOUT = 32'd50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       level_start,
   input  logic       e_pause,
   input  logic       e_resume,
   input  logic       e_start,
   input  logic       qbert_landed,
   input  logic [1:0] qb_on_sc,
   input  logic [1:0] done_move_sc,
   output logic [1:0] enable_sc,
   output logic [1:0] mode_saucer,
   output logic       ride_active,
   output logic       ride_sel,
   output logic       qbert_freeze,
   output logic       ride_done,
   output logic       ride_abort,
   output logic [1:0] sc_used,
   output logic       all_used
);

   state_e      state_q, state_d;
   logic        paused_q, paused_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  enable_q, enable_d;
   logic [1:0]  mode_q, mode_d;
   logic [1:0]  used_q, used_d;
   logic        all_used_q, all_used_d;
   slot_t       sel_q, sel_d;
   logic        freeze_q, freeze_d;
   logic        active_q, active_d;
   logic        done_q, done_d;
   logic        abort_q, abort_d;

   logic        w_pick_valid;
   slot_t       w_pick_idx;

   saucer_pick u_pick (
      .qb_on_sc_i (qb_on_sc),
      .sc_used_i  (used_q),
      .valid_o    (w_pick_valid),
      .idx_o      (w_pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      paused_d = paused_q;
      cnt_d    = cnt_q;
      enable_d = enable_q;
      mode_d   = mode_q;
      used_d   = used_q;
      sel_d    = sel_q;
      freeze_d = freeze_q;
      active_d = active_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;

      if (paused_q) begin
         // Everything, including any pulse in flight, is held while paused.
         done_d  = done_q;
         abort_d = abort_q;
         if (e_start) begin
            state_d  = ST_IDLE;
            paused_d = 1'b0;
            cnt_d    = 32'd0;
            enable_d = 2'b00;
            mode_d   = 2'b00;
            used_d   = 2'b00;
            sel_d    = 1'b0;
            freeze_d = 1'b0;
            active_d = 1'b0;
            done_d   = 1'b0;
            abort_d  = 1'b0;
         end else if (e_resume && !e_pause) begin
            paused_d = 1'b0;
         end
      end else begin
         // The cycle that samples e_pause still advances; freezing starts after it.
         if (e_pause && (state_q != ST_IDLE)) begin
            paused_d = 1'b1;
         end

         if (level_start) begin
            // Fresh level (or restart): no ride_done for an interrupted ride.
            state_d  = ST_ARMED;
            cnt_d    = 32'd0;
            enable_d = 2'b11;
            mode_d   = 2'b00;
            used_d   = 2'b00;
            freeze_d = 1'b0;
            active_d = 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
               end

               ST_ARMED: begin
                  // Only a completed jump boards; a pass-over does not.
                  if (qbert_landed && w_pick_valid) begin
                     sel_d    = w_pick_idx;
                     mode_d   = slot_mask(w_pick_idx);
                     freeze_d = 1'b1;
                     active_d = 1'b1;
                     cnt_d    = 32'd0;
                     state_d  = ST_RIDE;
                  end
               end

               ST_RIDE: begin
                  cnt_d = cnt_q + 32'd1;
                  if (done_move_sc[sel_q]) begin
                     cnt_d   = 32'd0;
                     state_d = ST_LAND;
                  end else if (cnt_q == (RIDE_TIMEOUT - 32'd1)) begin
                     abort_d  = 1'b1;
                     used_d   = used_q | slot_mask(sel_q);
                     enable_d = enable_q & ~slot_mask(sel_q);
                     mode_d   = 2'b00;
                     freeze_d = 1'b0;
                     active_d = 1'b0;
                     cnt_d    = 32'd0;
                     state_d  = ST_ARMED;
                  end
               end

               ST_LAND: begin
                  cnt_d = cnt_q + 32'd1;
                  if (cnt_q == (LAND_CYCLES - 32'd1)) begin
                     done_d   = 1'b1;
                     used_d   = used_q | slot_mask(sel_q);
                     enable_d = enable_q & ~slot_mask(sel_q);
                     mode_d   = 2'b00;
                     freeze_d = 1'b0;
                     active_d = 1'b0;
                     cnt_d    = 32'd0;
                     state_d  = ST_ARMED;
                  end
               end

               default: state_d = ST_IDLE;
            endcase
         end
      end

      all_used_d = (used_d == 2'b11);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         paused_q   <= 1'b0;
         cnt_q      <= 32'd0;
         enable_q   <= 2'b00;
         mode_q     <= 2'b00;
         used_q     <= 2'b00;
         all_used_q <= 1'b0;
         sel_q      <= 1'b0;
         freeze_q   <= 1'b0;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         paused_q   <= paused_d;
         cnt_q      <= cnt_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         used_q     <= used_d;
         all_used_q <= all_used_d;
         sel_q      <= sel_d;
         freeze_q   <= freeze_d;
         active_q   <= active_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
      end
   end

   assign enable_sc    = enable_q;
   assign mode_saucer  = mode_q;
   assign ride_active  = active_q;
   assign ride_sel     = sel_q;
   assign qbert_freeze = freeze_q;
   assign ride_done    = done_q;
   assign ride_abort   = abort_q;
   assign sc_used      = used_q;
   assign all_used     = all_used_q;

endmodule : saucer_scheduler
`default_nettype wire
